data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder_if.sv | 22 ++
 rtl/data_memory_responder.sv | 93 +++++++++
 tb/tb_data_memory_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// Request/response bus between an initiator and the data memory responder.
// Master drives req/we/a/wd; slave drives busy/ack/rd/err.
interface data_memory_responder_if;
  logic        req;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic        busy;
  logic        ack;
  logic [31:0] rd;
  logic        err;

  modport master (
    output req, we, a, wd,
    input  busy, ack, rd, err
  );

  modport slave (
    input  req, we, a, wd,
    output busy, ack, rd, err
  );
endinterface

// File: rtl/data_memory_responder.sv
// Fixed-latency word memory: accepts one access in IDLE, responds after
// LATENCY edges with a one-cycle ack. Ports: clk, rst_n (sync, active-low),
// bus (slave side: req/we/a/wd in, busy/ack/rd/err out).
module data_memory_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  data_memory_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW+1:0] a_q, a_d;
  logic [31:0]   wd_q, wd_d;

  logic [31:0] mem_q [DEPTH] = '{default: '0};

  logic          aligned;
  logic [AW-1:0] idx;
  logic          mem_wr;
  logic          unused_a_hi;

  // Address bits above the word index only alias, so they are never stored.
  assign unused_a_hi = ^bus.a[31:AW+2];

  assign aligned = (a_q[1:0] == 2'b00);
  assign idx     = a_q[AW+1:2];

  // Write lands on the same edge that moves WAIT -> RESP.
  assign mem_wr = rst_n && (state_q == WAIT) && (cnt_q == 4'd0)
                  && we_q && aligned;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    a_d     = a_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
          we_d    = bus.we;
          a_d     = bus.a[AW+1:0];
          wd_d    = bus.wd;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
    end
  end

  // Memory is outside the reset domain; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[idx] <= wd_q;
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.ack  = (state_q == RESP);
  assign bus.err  = bus.ack && !aligned;
  assign bus.rd   = (bus.ack && aligned && !we_q) ? mem_q[idx] : '0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder (LATENCY=2, DEPTH=64).
// Each task drives one scenario and checks against hand-computed values.
module tb_data_memory_responder;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  data_memory_responder_if bus ();

  data_memory_responder #(
    .LATENCY(2),
    .DEPTH  (64)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called #1 after an edge with the DUT idle. Scrambles inputs after
  // acceptance; returns edges-to-ack, captured rd/err, and ack one
  // cycle later.
  task automatic access(input logic w, input logic [31:0] addr,
                        input logic [31:0] data, output int lat,
                        output logic [31:0] rdv, output logic errv,
                        output logic ack_after);
    bus.req = 1'b1;
    bus.we  = w;
    bus.a   = addr;
    bus.wd  = data;
    @(posedge clk); #1;
    bus.req = 1'b0;
    bus.we  = ~w;
    bus.a   = addr ^ 32'h4;
    bus.wd  = ~data;
    lat  = -1;
    rdv  = '0;
    errv = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.ack) begin
        lat  = k;
        rdv  = bus.rd;
        errv = bus.err;
        break;
      end
    end
    @(posedge clk); #1;
    ack_after = bus.ack;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 1'b1;
    bus.we  = 1'b1;
    bus.a   = 32'h0;
    bus.wd  = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    bus.req = 1'b0;
    rst_n   = 1'b1;
    n_chk++;
    if ({bus.busy, bus.ack, bus.err} !== 3'b000 || bus.rd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: busy=%b ack=%b err=%b rd=%h want 0 0 0 0",
               bus.busy, bus.ack, bus.err, bus.rd);
    end
    @(posedge clk); #1;
    n_chk++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] r; logic e; logic aa;
    access(1'b1, 32'd8, 32'hDEAD_BEEF, lat, r, e, aa);
    n_chk++;
    if (lat !== 2 || e !== 1'b0 || aa !== 1'b0) begin
      n_fail++;
      $display("FAIL wr8: lat=%0d err=%b ack_after=%b want 2 0 0",
               lat, e, aa);
    end
    access(1'b0, 32'd8, 32'h0, lat, r, e, aa);
    n_chk++;
    if (lat !== 2 || r !== 32'hDEAD_BEEF || e !== 1'b0 || aa !== 1'b0) begin
      n_fail++;
      $display("FAIL rd8: lat=%0d rd=%h err=%b ack_after=%b want 2 deadbeef 0 0",
               lat, r, e, aa);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] r; logic e; logic aa;
    access(1'b1, 32'd4, 32'd7, lat, r, e, aa);
    n_chk++;
    if (lat !== 2 || e !== 1'b0 || r !== 32'h0) begin
      n_fail++;
      $display("FAIL wr4: lat=%0d err=%b rd=%h want 2 0 0", lat, e, r);
    end
    access(1'b0, 32'd260, 32'h0, lat, r, e, aa);
    n_chk++;
    if (r !== 32'd7 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL rd260: rd=%h err=%b want 7 0", r, e);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] r; logic e; logic aa;
    access(1'b1, 32'd6, 32'd5, lat, r, e, aa);
    n_chk++;
    if (lat !== 2 || e !== 1'b1 || r !== 32'h0 || aa !== 1'b0) begin
      n_fail++;
      $display("FAIL wr6: lat=%0d err=%b rd=%h ack_after=%b want 2 1 0 0",
               lat, e, r, aa);
    end
    access(1'b0, 32'd4, 32'h0, lat, r, e, aa);
    n_chk++;
    if (r !== 32'd7 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL rd4_after_err: rd=%h err=%b want 7 0", r, e);
    end
    access(1'b0, 32'd9, 32'h0, lat, r, e, aa);
    n_chk++;
    if (r !== 32'h0 || e !== 1'b1) begin
      n_fail++;
      $display("FAIL rd9: rd=%h err=%b want 0 1", r, e);
    end
  endtask

  // With req held high an access is accepted every LATENCY+2 edges:
  // accept, LATENCY edges in WAIT, one RESP, back in IDLE.
  task automatic test_back_to_back();
    int lat; logic [31:0] r; logic e; logic aa;
    logic [31:0] tab [12];
    logic [31:0] exp_rd;
    logic        exp_ack;
    logic        exp_busy;
    access(1'b1, 32'd16, 32'hA5A5_0001, lat, r, e, aa);
    tab = '{32'd8,   32'h30, 32'h34, 32'h38,
            32'd4,   32'h30, 32'h34, 32'h38,
            32'd272, 32'h30, 32'h34, 32'h38};
    bus.req = 1'b1;
    bus.we  = 1'b0;
    for (int c = 0; c < 12; c++) begin
      bus.a  = tab[c];
      bus.wd = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      exp_ack  = ((c % 4) == 2);
      exp_busy = ((c % 4) != 3);
      exp_rd   = 32'h0;
      if (c == 2)  exp_rd = 32'hDEAD_BEEF;
      if (c == 6)  exp_rd = 32'd7;
      if (c == 10) exp_rd = 32'hA5A5_0001;
      n_chk++;
      if (bus.ack !== exp_ack || bus.busy !== exp_busy ||
          bus.rd !== exp_rd || bus.err !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b[%0d]: ack=%b busy=%b rd=%h err=%b want %b %b %h 0",
                 c, bus.ack, bus.busy, bus.rd, bus.err,
                 exp_ack, exp_busy, exp_rd);
      end
    end
    bus.req = 1'b0;
  endtask

  task automatic test_reset_during_wait();
    int lat; logic [31:0] r; logic e; logic aa;
    int acks;
    for (int s = 1; s <= 2; s++) begin
      bus.req = 1'b1;
      bus.we  = 1'b1;
      bus.a   = 32'd12;
      bus.wd  = 32'd9;
      @(posedge clk); #1;
      bus.req = 1'b0;
      // s=1: reset on first WAIT edge; s=2: on the edge entering RESP
      if (s == 2) begin
        @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_chk++;
      if (bus.busy !== 1'b0 || bus.ack !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_wait%0d: busy=%b ack=%b want 0 0",
                 s, bus.busy, bus.ack);
      end
      acks = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (bus.ack) acks++;
      end
      n_chk++;
      if (acks !== 0) begin
        n_fail++;
        $display("FAIL rst_noack%0d: acks=%0d want 0", s, acks);
      end
    end
    access(1'b0, 32'd12, 32'h0, lat, r, e, aa);
    n_chk++;
    if (lat !== 2 || r !== 32'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL rd12: lat=%0d rd=%h err=%b want 2 0 0", lat, r, e);
    end
    access(1'b0, 32'd8, 32'h0, lat, r, e, aa);
    n_chk++;
    if (r !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL rd8_kept: rd=%h want deadbeef", r);
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.req = 1'b0;
    bus.we  = 1'b0;
    bus.a   = '0;
    bus.wd  = '0;
    test_reset();
    test_write_read();
    test_wrap();
    test_misaligned();
    test_back_to_back();
    test_reset_during_wait();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
